vga_text_scan: RTL and testbench



---
 rtl/vga_text_pkg.sv | 38 +++
 rtl/vga_timing.sv | 79 +++++++
 rtl/vga_text_scan.sv | 127 ++++++++++++
 tb/tb_vga_text_scan.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_text_pkg.sv
// Shared constants for the text-mode raster scan: default 640x480@60 timing,
// character-cell geometry and the text-RAM word layout.
package vga_text_pkg;

    // Default 640x480@60 Hz timing at a 25 MHz pixel clock
    localparam int H_ACTIVE_DEF   = 640;
    localparam int H_FP_DEF       = 16;
    localparam int H_SYNC_DEF     = 96;
    localparam int H_BP_DEF       = 48;
    localparam int V_ACTIVE_DEF   = 480;
    localparam int V_FP_DEF       = 10;
    localparam int V_SYNC_DEF     = 2;
    localparam int V_BP_DEF       = 33;

    localparam int H_TOTAL_DEF    = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;  // 800
    localparam int V_TOTAL_DEF    = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;  // 525

    localparam int HS_START_DEF   = H_ACTIVE_DEF + H_FP_DEF;                          // 656
    localparam int HS_END_DEF     = HS_START_DEF + H_SYNC_DEF - 1;                    // 751
    localparam int VS_START_DEF   = V_ACTIVE_DEF + V_FP_DEF;                          // 490
    localparam int VS_END_DEF     = VS_START_DEF + V_SYNC_DEF - 1;                    // 491

    // Character grid: 8x16 pixel cells, 80x30 cells
    localparam int COLS_DEF       = 80;
    localparam int ROWS           = 30;
    localparam int BLINK_BITS_DEF = 5;
    localparam int VRAM_MAX_ADDR  = ROWS * COLS_DEF - 1;                              // 2399

    // Text-RAM word layout
    localparam int BLINK_BIT      = 23;
    localparam int CHAR_MSB       = 22;
    localparam int CHAR_LSB       = 16;
    localparam int FONT_MSB       = 15;
    localparam int FONT_LSB       = 8;
    localparam int BACK_MSB       = 7;
    localparam int BACK_LSB       = 0;

endpackage

// File: rtl/vga_timing.sv
// Stage 0 of the scan: pixel/line/frame counters and the combinational
// sync and visible-area decode taken straight from the counters.
module vga_timing
    import vga_text_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter int BLINK_BITS = BLINK_BITS_DEF
)
(
    input  logic       clk,
    input  logic       clr_n,
    output logic [9:0] hcnt,
    output logic [9:0] vcnt,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       visible,
    output logic       frame_msb
);

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);

    logic [9:0]            hcnt_q, hcnt_d;
    logic [9:0]            vcnt_q, vcnt_d;
    logic [BLINK_BITS-1:0] frame_q, frame_d;
    logic                  line_end;
    logic                  frame_end;

    // Next-state: pixel counter wraps each line, line counter and frame
    // counter advance on the same edge as the wrap that carries into them.
    always_comb begin
        line_end  = (hcnt_q == H_LAST);
        frame_end = line_end && (vcnt_q == V_LAST);
        hcnt_d    = line_end ? 10'd0 : hcnt_q + 10'd1;
        vcnt_d    = vcnt_q;
        if (line_end) begin
            vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
        end
        frame_d   = frame_end ? frame_q + 1'b1 : frame_q;
    end

    // Counter registers; reset restarts the scan at pixel (0,0) of frame 0.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            frame_q <= '0;
        end else begin
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            frame_q <= frame_d;
        end
    end

    // Sync and visible-area decode for the pixel currently addressed.
    always_comb begin
        hsync_n = !((hcnt_q >= HS_START) && (hcnt_q <= HS_END));
        vsync_n = !((vcnt_q >= VS_START) && (vcnt_q <= VS_END));
        visible = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
    end

    assign hcnt      = hcnt_q;
    assign vcnt      = vcnt_q;
    assign frame_msb = frame_q[BLINK_BITS-1];

endmodule

// File: rtl/vga_text_scan.sv
// Raster scan and text-RAM fetch stage. Issues one text-RAM address per pixel
// from the stage-0 counters and registers sync/position/valid by one clock so
// they line up with the RAM's registered read data for the same pixel.
module vga_text_scan
    import vga_text_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter int COLS       = COLS_DEF,
    parameter int BLINK_BITS = BLINK_BITS_DEF
)
(
    input  logic        clk,
    input  logic        clr_n,
    output logic [11:0] vram_addr,
    input  logic [23:0] vram_data,
    output logic [6:0]  char,
    output logic [7:0]  fontcolor,
    output logic [7:0]  backcolor,
    output logic        Blink,
    output logic        cBlink,
    output logic        xsync,
    output logic        ysync,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        valid
);

    logic [9:0]  hcnt;
    logic [9:0]  vcnt;
    logic        hsync_n;
    logic        vsync_n;
    logic        visible;
    logic        frame_msb;

    logic [11:0] row_base;
    logic [11:0] cell_addr;

    logic        xsync_q, xsync_d;
    logic        ysync_q, ysync_d;
    logic [11:0] xpos_q, xpos_d;
    logic [11:0] ypos_q, ypos_d;
    logic        valid_q, valid_d;
    logic        cblink_q, cblink_d;

    vga_timing #(
        .H_ACTIVE   (H_ACTIVE),
        .H_FP       (H_FP),
        .H_SYNC     (H_SYNC),
        .H_BP       (H_BP),
        .V_ACTIVE   (V_ACTIVE),
        .V_FP       (V_FP),
        .V_SYNC     (V_SYNC),
        .V_BP       (V_BP),
        .BLINK_BITS (BLINK_BITS)
    ) u_timing (
        .clk       (clk),
        .clr_n     (clr_n),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .hsync_n   (hsync_n),
        .vsync_n   (vsync_n),
        .visible   (visible),
        .frame_msb (frame_msb)
    );

    // Cell address row*COLS+col; forced to 0 in blanking so the RAM only ever
    // sees in-range addresses, and saturated as a guard on odd geometries.
    always_comb begin
        row_base  = 12'(vcnt[8:4]) * 12'(COLS);
        cell_addr = row_base + 12'(hcnt[9:3]);
        vram_addr = 12'd0;
        if (visible) begin
            vram_addr = (cell_addr > 12'(VRAM_MAX_ADDR)) ? 12'(VRAM_MAX_ADDR) : cell_addr;
        end
    end

    // Stage-1 next values: the stage-0 decode for the pixel whose RAM read
    // is in flight this cycle.
    always_comb begin
        xsync_d  = hsync_n;
        ysync_d  = vsync_n;
        xpos_d   = {2'b00, hcnt};
        ypos_d   = {2'b00, vcnt};
        valid_d  = visible;
        cblink_d = frame_msb;
    end

    // Stage-1 alignment registers; reset shows an idle, sync-inactive output.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            xsync_q  <= 1'b1;
            ysync_q  <= 1'b1;
            xpos_q   <= '0;
            ypos_q   <= '0;
            valid_q  <= 1'b0;
            cblink_q <= 1'b0;
        end else begin
            xsync_q  <= xsync_d;
            ysync_q  <= ysync_d;
            xpos_q   <= xpos_d;
            ypos_q   <= ypos_d;
            valid_q  <= valid_d;
            cblink_q <= cblink_d;
        end
    end

    assign xsync     = xsync_q;
    assign ysync     = ysync_q;
    assign xpos      = xpos_q;
    assign ypos      = ypos_q;
    assign valid     = valid_q;
    assign cBlink    = cblink_q;

    // Attributes come straight from the RAM's own output register.
    assign Blink     = vram_data[BLINK_BIT];
    assign char      = vram_data[CHAR_MSB:CHAR_LSB];
    assign fontcolor = vram_data[FONT_MSB:FONT_LSB];
    assign backcolor = vram_data[BACK_MSB:BACK_LSB];

endmodule

// File: tb/tb_vga_text_scan.sv
// Directed bench for vga_text_scan. Instance A uses full 640x480 timing for the
// horizontal and address checks; instance B uses a shrunken raster
// (H 16/2/4/2 = 24, V 32/1/2/1 = 36, 864 clks per frame) so vertical sync,
// frame wrap, blink phase and mid-frame reset fit in a short run.
module tb_vga_text_scan;

    logic        clk;
    logic        ra_n;
    logic        rb_n;

    logic [11:0] a_addr,  b_addr;
    logic [23:0] a_ram,   b_ram;
    logic [6:0]  a_char,  b_char;
    logic [7:0]  a_font,  b_font;
    logic [7:0]  a_back,  b_back;
    logic        a_blink, b_blink;
    logic        a_cblink, b_cblink;
    logic        a_xsync, b_xsync;
    logic        a_ysync, b_ysync;
    logic [11:0] a_xpos,  b_xpos;
    logic [11:0] a_ypos,  b_ypos;
    logic        a_valid, b_valid;

    int n_vec;
    int n_err;
    int ea;
    int eb;
    int lo_cnt;
    int first_lo;

    vga_text_scan dut_a (
        .clk       (clk),
        .clr_n     (ra_n),
        .vram_addr (a_addr),
        .vram_data (a_ram),
        .char      (a_char),
        .fontcolor (a_font),
        .backcolor (a_back),
        .Blink     (a_blink),
        .cBlink    (a_cblink),
        .xsync     (a_xsync),
        .ysync     (a_ysync),
        .xpos      (a_xpos),
        .ypos      (a_ypos),
        .valid     (a_valid)
    );

    vga_text_scan #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (2),
        .V_ACTIVE (32), .V_FP (1), .V_SYNC (2), .V_BP (1)
    ) dut_b (
        .clk       (clk),
        .clr_n     (rb_n),
        .vram_addr (b_addr),
        .vram_data (b_ram),
        .char      (b_char),
        .fontcolor (b_font),
        .backcolor (b_back),
        .Blink     (b_blink),
        .cBlink    (b_cblink),
        .xsync     (b_xsync),
        .ysync     (b_ysync),
        .xpos      (b_xpos),
        .ypos      (b_ypos),
        .valid     (b_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model text RAM with one-cycle registered read
    function automatic logic [23:0] ram_word(input logic [11:0] addr);
        if (addr == 12'd81) return {1'b1, 7'h41, 8'hE0, 8'h03};
        return {1'b0, addr[6:0], 8'h00, 8'h5A};
    endfunction

    always @(posedge clk) begin
        a_ram <= ram_word(a_addr);
        b_ram <= ram_word(b_addr);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (ra_n) ea++;
        if (rb_n) eb++;
    endtask

    task automatic run_a(input int target);
        while (ea < target) tick();
    endtask

    task automatic run_b(input int target);
        while (eb < target) tick();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        ea    = 0;
        eb    = 0;
        ra_n  = 1'b0;
        rb_n  = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_xsync",  32'(a_xsync),  32'd1);
        chk("rst_ysync",  32'(a_ysync),  32'd1);
        chk("rst_valid",  32'(a_valid),  32'd0);
        chk("rst_xpos",   32'(a_xpos),   32'd0);
        chk("rst_ypos",   32'(a_ypos),   32'd0);
        chk("rst_cblink", 32'(a_cblink), 32'd0);
        chk("rst_addr",   32'(a_addr),   32'd0);
        chk("rst_b_valid", 32'(b_valid), 32'd0);

        // First edge after release shows pixel (0,0)
        ra_n = 1'b1;
        tick();
        chk("rel_xpos",  32'(a_xpos),  32'd0);
        chk("rel_ypos",  32'(a_ypos),  32'd0);
        chk("rel_valid", 32'(a_valid), 32'd1);
        chk("rel_addr",  32'(a_addr),  32'd0);

        // Address walk along line 0, hcnt 2..15
        for (int h = 2; h <= 15; h++) begin
            tick();
            chk("walk_addr", 32'(a_addr), (h < 8) ? 32'd0 : 32'd1);
            chk("walk_xpos", 32'(a_xpos), 32'(h - 1));
        end

        // Right edge of the visible area and horizontal blanking
        run_a(639);
        chk("h_last_addr", 32'(a_addr), 32'd79);
        run_a(640);
        chk("h_blank_addr", 32'(a_addr),  32'd0);
        chk("h_last_valid", 32'(a_valid), 32'd1);
        run_a(641);
        chk("h_blank_valid", 32'(a_valid), 32'd0);
        chk("h_blank_addr2", 32'(a_addr),  32'd0);

        // Horizontal sync pulse width and position
        lo_cnt   = 0;
        first_lo = -1;
        while (ea < 800) begin
            tick();
            if (!a_xsync) begin
                lo_cnt++;
                if (first_lo < 0) first_lo = ea;
            end
        end
        chk("hsync_width", 32'(lo_cnt),   32'd96);
        chk("hsync_start", 32'(first_lo), 32'd657);
        chk("eol_xpos",  32'(a_xpos),  32'd799);
        chk("eol_valid", 32'(a_valid), 32'd0);

        // Line wrap
        run_a(801);
        chk("wrap_xpos",  32'(a_xpos),  32'd0);
        chk("wrap_ypos",  32'(a_ypos),  32'd1);
        chk("wrap_valid", 32'(a_valid), 32'd1);

        // Line 16: row 1 addressing and attribute alignment
        run_a(12807);
        chk("row1_addr0", 32'(a_addr), 32'd80);
        run_a(12808);
        chk("row1_addr1", 32'(a_addr),  32'd81);
        chk("pre_char",   32'(a_char),  32'h50);
        chk("pre_blink",  32'(a_blink), 32'd0);
        run_a(12809);
        chk("al_xpos",  32'(a_xpos),  32'd8);
        chk("al_ypos",  32'(a_ypos),  32'd16);
        chk("al_char",  32'(a_char),  32'h41);
        chk("al_blink", 32'(a_blink), 32'd1);
        chk("al_font",  32'(a_font),  32'hE0);
        chk("al_back",  32'(a_back),  32'h03);

        // Mid-line reset on A: outputs clear without a clock edge
        run_a(12900);
        chk("pre_rst_xpos", 32'(a_xpos), 32'd99);
        ra_n = 1'b0;
        #1;
        chk("arst_xpos",  32'(a_xpos),  32'd0);
        chk("arst_ypos",  32'(a_ypos),  32'd0);
        chk("arst_valid", 32'(a_valid), 32'd0);
        chk("arst_addr",  32'(a_addr),  32'd0);
        ea = 0;
        tick();
        tick();
        ra_n = 1'b1;
        tick();
        chk("arestart_xpos",  32'(a_xpos),  32'd0);
        chk("arestart_ypos",  32'(a_ypos),  32'd0);
        chk("arestart_valid", 32'(a_valid), 32'd1);
        tick();
        chk("arestart_xpos1", 32'(a_xpos),  32'd1);

        // Instance B: vertical behaviour on the shrunken raster
        rb_n = 1'b1;
        tick();
        chk("b_rel_xpos",  32'(b_xpos),  32'd0);
        chk("b_rel_valid", 32'(b_valid), 32'd1);

        run_b(759);
        chk("b_max_addr", 32'(b_addr), 32'd81);
        run_b(760);
        chk("b_hblank_addr", 32'(b_addr),  32'd0);
        chk("b_last_valid",  32'(b_valid), 32'd1);
        run_b(761);
        chk("b_hblank_valid", 32'(b_valid), 32'd0);
        run_b(771);
        chk("b_vblank_addr", 32'(b_addr), 32'd0);
        run_b(772);
        chk("b_vblank_valid", 32'(b_valid), 32'd0);
        chk("b_vblank_ypos",  32'(b_ypos),  32'd32);

        lo_cnt   = 0;
        first_lo = -1;
        while (eb < 864) begin
            tick();
            if (!b_ysync) begin
                lo_cnt++;
                if (first_lo < 0) first_lo = eb;
            end
        end
        chk("vsync_width", 32'(lo_cnt),   32'd48);
        chk("vsync_start", 32'(first_lo), 32'd793);

        run_b(865);
        chk("fwrap_xpos",  32'(b_xpos),  32'd0);
        chk("fwrap_ypos",  32'(b_ypos),  32'd0);
        chk("fwrap_valid", 32'(b_valid), 32'd1);

        // Blink phase: rises after 16 frames, falls after 32
        run_b(13824);
        chk("blink_pre_rise", 32'(b_cblink), 32'd0);
        run_b(13825);
        chk("blink_rise",      32'(b_cblink), 32'd1);
        chk("blink_rise_xpos", 32'(b_xpos),   32'd0);
        chk("blink_rise_ypos", 32'(b_ypos),   32'd0);
        run_b(27648);
        chk("blink_pre_fall", 32'(b_cblink), 32'd1);
        run_b(27649);
        chk("blink_fall", 32'(b_cblink), 32'd0);
        run_b(41473);
        chk("blink_rise2", 32'(b_cblink), 32'd1);

        // Mid-frame reset on B inside both sync pulses with blink phase high
        run_b(42284);
        chk("b_pre_xpos",  32'(b_xpos),  32'd19);
        chk("b_pre_ypos",  32'(b_ypos),  32'd33);
        chk("b_pre_xsync", 32'(b_xsync), 32'd0);
        chk("b_pre_ysync", 32'(b_ysync), 32'd0);
        rb_n = 1'b0;
        #1;
        chk("brst_xsync",  32'(b_xsync),  32'd1);
        chk("brst_ysync",  32'(b_ysync),  32'd1);
        chk("brst_cblink", 32'(b_cblink), 32'd0);
        chk("brst_xpos",   32'(b_xpos),   32'd0);
        chk("brst_ypos",   32'(b_ypos),   32'd0);
        chk("brst_addr",   32'(b_addr),   32'd0);
        eb = 0;
        tick();
        rb_n = 1'b1;
        tick();
        chk("brestart_xpos",   32'(b_xpos),   32'd0);
        chk("brestart_ypos",   32'(b_ypos),   32'd0);
        chk("brestart_valid",  32'(b_valid),  32'd1);
        chk("brestart_cblink", 32'(b_cblink), 32'd0);
        tick();
        chk("brestart_xpos1", 32'(b_xpos), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
